// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: width codes, FSM encodings, error causes
// and the accept-time legality check.
package load_store_unit_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_REQ  = 2'b01;
    localparam logic [1:0] ST_WAIT = 2'b10;
    localparam logic [1:0] ST_RESP = 2'b11;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_WIDTH    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    // Everything latched at accept except the address, whose width is a parameter.
    typedef struct packed {
        logic        is_store;
        logic [2:0]  funct3;
        logic [31:0] wdata;
        logic [4:0]  rd;
    } lsu_req_t;

    // Illegal width wins over misalignment.
    function automatic logic [1:0] lsu_check(input logic       is_store,
                                             input logic [2:0] funct3,
                                             input logic [1:0] off);
        logic illegal;
        logic misaligned;
        illegal    = (funct3 inside {3'b011, 3'b110, 3'b111}) || (is_store && (funct3 > LSU_W));
        misaligned = ((funct3[1:0] == 2'b01) && off[0]) ||
                     ((funct3[1:0] == 2'b10) && (off != 2'b00));
        if (illegal) begin
            return ERR_WIDTH;
        end else if (misaligned) begin
            return ERR_MISALIGN;
        end
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the LSU (master) and memory (slave): single outstanding
// request/grant followed by a read-valid response for loads.
interface load_store_unit_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic              gnt;
    logic              rvalid;
    logic [31:0]       rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/load_store_unit_align.sv
// Byte-lane steering: store byte enables and lane replication, load extract and extend.
module load_store_unit_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << offset_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_o    = offset_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
            end
        endcase
    end

    always_comb begin
        shifted = rdata_i >> {offset_i, 3'b000};
        case (funct3_i)
            LSU_B:   rdata_o = {{24{shifted[7]}}, shifted[7:0]};
            LSU_H:   rdata_o = {{16{shifted[15]}}, shifted[15:0]};
            LSU_BU:  rdata_o = {24'b0, shifted[7:0]};
            LSU_HU:  rdata_o = {16'b0, shifted[15:0]};
            default: rdata_o = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: takes the ALU effective address, runs one bus transaction at a time and
// returns extended load data or an error cause to writeback.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              is_store_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    input  logic [4:0]        rd_i,
    input  logic              flush_i,
    load_store_unit_if.master mem_if,
    output logic              done_o,
    output logic              wb_we_o,
    output logic [4:0]        wb_rd_o,
    output logic [31:0]       wb_data_o,
    output logic              err_o,
    output logic [1:0]        err_cause_o
);

    localparam int unsigned CntW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT + 1) : 1;

    logic [1:0]        state_q, state_d;
    lsu_req_t          req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              drop_q, drop_d;
    logic [CntW-1:0]   tmo_q, tmo_d;
    logic              resp_we_q, resp_we_d;
    logic [31:0]       resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;
    logic [1:0]        resp_cause_q, resp_cause_d;

    logic [1:0]  accept_cause;
    logic        tmo_hit;
    logic        in_req;
    logic        in_resp;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;

    load_store_unit_align u_align (
        .funct3_i (req_q.funct3),
        .offset_i (addr_q[1:0]),
        .wdata_i  (req_q.wdata),
        .rdata_i  (mem_if.rdata),
        .be_o     (lane_be),
        .wdata_o  (lane_wdata),
        .rdata_o  (load_data)
    );

    assign accept_cause = lsu_check(is_store_i, funct3_i, addr_i[1:0]);
    assign tmo_hit      = (WAIT_TIMEOUT != 0) && ((32'(tmo_q) + 32'd1) == WAIT_TIMEOUT);

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        addr_d       = addr_q;
        drop_d       = drop_q;
        tmo_d        = tmo_q;
        resp_we_d    = resp_we_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        resp_cause_d = resp_cause_q;
        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    req_d        = '{is_store: is_store_i, funct3: funct3_i,
                                     wdata: wdata_i, rd: rd_i};
                    addr_d       = addr_i;
                    drop_d       = 1'b0;
                    tmo_d        = '0;
                    resp_we_d    = 1'b0;
                    resp_data_d  = '0;
                    resp_err_d   = (accept_cause != ERR_NONE);
                    resp_cause_d = accept_cause;
                    state_d      = (accept_cause != ERR_NONE) ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_if.gnt) begin
                    if (req_q.is_store) begin
                        state_d = flush_i ? ST_IDLE : ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        drop_d  = flush_i;
                        tmo_d   = '0;
                    end
                end else if (flush_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // A flushed load still waits for its response so the bus stays in step.
                if (mem_if.rvalid) begin
                    if (drop_q || flush_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d     = ST_RESP;
                        resp_we_d   = 1'b1;
                        resp_data_d = load_data;
                    end
                end else if (tmo_hit) begin
                    if (drop_q || flush_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d      = ST_RESP;
                        resp_err_d   = 1'b1;
                        resp_cause_d = ERR_TIMEOUT;
                    end
                end else begin
                    tmo_d  = tmo_q + CntW'(1);
                    drop_d = drop_q | flush_i;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            addr_q       <= '0;
            drop_q       <= 1'b0;
            tmo_q        <= '0;
            resp_we_q    <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            resp_cause_q <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            drop_q       <= drop_d;
            tmo_q        <= tmo_d;
            resp_we_q    <= resp_we_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            resp_cause_q <= resp_cause_d;
        end
    end

    assign in_req  = (state_q == ST_REQ);
    assign in_resp = (state_q == ST_RESP);

    assign ready_o      = (state_q == ST_IDLE);
    assign mem_if.req   = in_req;
    assign mem_if.we    = in_req & req_q.is_store;
    assign mem_if.addr  = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_if.be    = in_req ? lane_be : 4'b0000;
    assign mem_if.wdata = in_req ? lane_wdata : 32'h0;

    assign done_o      = in_resp;
    assign wb_we_o     = in_resp & resp_we_q;
    assign wb_rd_o     = in_resp ? req_q.rd : 5'd0;
    assign wb_data_o   = in_resp ? resp_data_q : 32'h0;
    assign err_o       = in_resp & resp_err_q;
    assign err_cause_o = in_resp ? resp_cause_q : ERR_NONE;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a table of single accesses against a simple memory
// responder, then hand-written flush, timeout and reset sequences.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        ready;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        flush;
    logic        done;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err;
    logic [1:0]  cause;

    int n_chk  = 0;
    int n_fail = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_W(32)) mem_if ();

    load_store_unit #(
        .ADDR_W       (32),
        .WAIT_TIMEOUT (4)
    ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .valid_i     (valid),
        .ready_o     (ready),
        .is_store_i  (is_store),
        .funct3_i    (funct3),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .rd_i        (rd),
        .flush_i     (flush),
        .mem_if      (mem_if),
        .done_o      (done),
        .wb_we_o     (wb_we),
        .wb_rd_o     (wb_rd),
        .wb_data_o   (wb_data),
        .err_o       (err),
        .err_cause_o (cause)
    );

    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gd;
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [1:0]  cause;
        logic [31:0] data;
        int          lat;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] r);
        valid    = 1'b1;
        is_store = st;
        funct3   = f3;
        addr     = a;
        wdata    = wd;
        rd       = r;
        @(negedge clk);
        chk("accept_ready", 32'(ready), 32'd1);
        step();
        valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input logic [4:0] r);
        int  n;
        int  req_cycles;
        bit  req_seen;
        bit  done_seen;
        bit  rv_pend;
        n = 1; req_cycles = 0; req_seen = 0; done_seen = 0; rv_pend = 0;
        accept(v.st, v.f3, v.addr, v.wdata, r);
        while (n <= 20 && !done_seen) begin
            mem_if.rvalid = rv_pend;
            mem_if.rdata  = rv_pend ? v.rdata : 32'h0;
            rv_pend       = 1'b0;
            mem_if.gnt    = 1'b0;
            if (mem_if.req) begin
                if (req_cycles == v.gd) begin
                    mem_if.gnt = 1'b1;
                    rv_pend    = !v.st;
                end
                req_cycles++;
            end
            @(negedge clk);
            if (mem_if.req && !req_seen) begin
                req_seen = 1;
                chk("bus_addr", mem_if.addr, v.maddr);
                chk("bus_we", 32'(mem_if.we), 32'(v.st));
                if (v.st) begin
                    chk("bus_be", 32'(mem_if.be), 32'(v.be));
                    chk("bus_wdata", mem_if.wdata, v.mwdata);
                end
            end
            if (done) begin
                done_seen = 1;
                chk("latency", 32'(n), 32'(v.lat));
                chk("err", 32'(err), 32'(v.cause != ERR_NONE));
                chk("err_cause", 32'(cause), 32'(v.cause));
                chk("wb_we", 32'(wb_we), 32'(!v.st && v.cause == ERR_NONE));
                chk("wb_data", wb_data, v.data);
                if (!v.st && v.cause == ERR_NONE) chk("wb_rd", 32'(wb_rd), 32'(r));
            end
            step();
            n++;
        end
        mem_if.gnt    = 1'b0;
        mem_if.rvalid = 1'b0;
        if (!done_seen) chk("done_seen", 32'd0, 32'd1);
        chk("req_seen", 32'(req_seen), 32'(v.cause == ERR_NONE));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0;
        rst = 1'b1; valid = 1'b0; is_store = 1'b0; funct3 = 3'b0; addr = 32'h0;
        wdata = 32'h0; rd = 5'd0; flush = 1'b0;
        mem_if.gnt = 1'b0; mem_if.rvalid = 1'b0; mem_if.rdata = 32'h0;

        //        st    f3      addr          wdata         rdata     gd  be       maddr         mwdata        cause  data          lat
        vecs[0]  = '{1'b1, LSU_W,  32'h100, 32'hDEADBEEF, 32'h0,        0, 4'b1111, 32'h100, 32'hDEADBEEF, 2'd0, 32'h0,        2};
        vecs[1]  = '{1'b0, LSU_B,  32'h203, 32'h0,        32'h80FF0000, 0, 4'b1000, 32'h200, 32'h0,        2'd0, 32'hFFFFFF80, 3};
        vecs[2]  = '{1'b0, LSU_BU, 32'h203, 32'h0,        32'h80FF0000, 0, 4'b1000, 32'h200, 32'h0,        2'd0, 32'h00000080, 3};
        vecs[3]  = '{1'b1, LSU_H,  32'h302, 32'hABCD1234, 32'h0,        0, 4'b1100, 32'h300, 32'h12341234, 2'd0, 32'h0,        2};
        vecs[4]  = '{1'b0, LSU_W,  32'h101, 32'h0,        32'h0,        0, 4'b0000, 32'h0,   32'h0,        2'd1, 32'h0,        1};
        vecs[5]  = '{1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        0, 4'b0000, 32'h0,   32'h0,        2'd2, 32'h0,        1};
        vecs[6]  = '{1'b1, LSU_B,  32'h105, 32'h000000A5, 32'h0,        2, 4'b0010, 32'h104, 32'hA5A5A5A5, 2'd0, 32'h0,        4};
        vecs[7]  = '{1'b0, LSU_H,  32'h402, 32'h0,        32'h80011234, 0, 4'b1100, 32'h400, 32'h0,        2'd0, 32'hFFFF8001, 3};
        vecs[8]  = '{1'b0, LSU_HU, 32'h400, 32'h0,        32'h8001F234, 0, 4'b0011, 32'h400, 32'h0,        2'd0, 32'h0000F234, 3};
        vecs[9]  = '{1'b0, LSU_W,  32'h500, 32'h0,        32'hCAFEF00D, 1, 4'b1111, 32'h500, 32'h0,        2'd0, 32'hCAFEF00D, 4};
        vecs[10] = '{1'b1, LSU_W,  32'h102, 32'h11111111, 32'h0,        0, 4'b0000, 32'h0,   32'h0,        2'd1, 32'h0,        1};
        vecs[11] = '{1'b1, 3'b100, 32'h101, 32'h11111111, 32'h0,        0, 4'b0000, 32'h0,   32'h0,        2'd2, 32'h0,        1};
        vecs[12] = '{1'b0, LSU_H,  32'h401, 32'h0,        32'h0,        0, 4'b0000, 32'h0,   32'h0,        2'd1, 32'h0,        1};
        vecs[13] = '{1'b0, 3'b111, 32'h200, 32'h0,        32'h0,        0, 4'b0000, 32'h0,   32'h0,        2'd2, 32'h0,        1};
        vecs[14] = '{1'b1, LSU_B,  32'h003, 32'h12345678, 32'h0,        0, 4'b1000, 32'h000, 32'h78787878, 2'd0, 32'h0,        2};

        step(); step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_req", 32'(mem_if.req), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_outs", {wb_data[29:0], wb_we, err}, 32'd0);
        chk("rst_bus", {mem_if.addr[27:0], mem_if.be}, 32'd0);
        step();

        for (int i = 0; i < 15; i++) run_vec(vecs[i], 5'(i + 1));

        // Load with grant held off three cycles, flushed in WAIT.
        accept(1'b0, LSU_W, 32'h600, 32'h0, 5'd7);
        c0 = done_cnt;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_req", 32'(mem_if.req), 32'd1);
            step();
        end
        mem_if.gnt = 1'b1;
        step();
        mem_if.gnt = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_wait_busy", 32'(ready), 32'd0);
        step();
        flush = 1'b0;
        mem_if.rvalid = 1'b1;
        mem_if.rdata  = 32'h12345678;
        @(negedge clk);
        chk("flush_rvalid_busy", 32'(ready), 32'd0);
        step();
        mem_if.rvalid = 1'b0;
        @(negedge clk);
        chk("flush_ready_after", 32'(ready), 32'd1);
        step(); step();
        chk("flush_no_done", 32'(done_cnt - c0), 32'd0);

        // Timeout: grant at once, rvalid never comes.
        accept(1'b0, LSU_W, 32'h700, 32'h0, 5'd9);
        mem_if.gnt = 1'b1;
        c0 = done_cnt;
        step();
        mem_if.gnt = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("tmo_not_early", 32'(done_cnt - c0), 32'd0);
        @(negedge clk);
        chk("tmo_done", 32'(done), 32'd1);
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_cause", 32'(cause), 32'(ERR_TIMEOUT));
        chk("tmo_wb_we", 32'(wb_we), 32'd0);
        step();
        mem_if.rvalid = 1'b1;
        step();
        mem_if.rvalid = 1'b0;
        c0 = done_cnt;
        step(); step();
        chk("stray_no_done", 32'(done_cnt - c0), 32'd0);
        chk("stray_ready", 32'(ready), 32'd1);

        // Reset while requesting.
        accept(1'b1, LSU_W, 32'h800, 32'h55AA55AA, 5'd0);
        rst = 1'b1;
        c0 = done_cnt;
        @(negedge clk);
        chk("rstreq_req_before", 32'(mem_if.req), 32'd1);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rstreq_req_after", 32'(mem_if.req), 32'd0);
        chk("rstreq_ready", 32'(ready), 32'd1);
        step(); step();
        chk("rstreq_no_done", 32'(done_cnt - c0), 32'd0);

        // Flush in REQ without grant drops the request.
        accept(1'b0, LSU_W, 32'h900, 32'h0, 5'd3);
        flush = 1'b1;
        c0 = done_cnt;
        @(negedge clk);
        chk("flushreq_req", 32'(mem_if.req), 32'd1);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("flushreq_dropped", 32'(mem_if.req), 32'd0);
        chk("flushreq_ready", 32'(ready), 32'd1);
        step(); step();
        chk("flushreq_no_done", 32'(done_cnt - c0), 32'd0);

        // Flush during RESP has no effect.
        accept(1'b0, LSU_W, 32'h101, 32'h0, 5'd4);
        flush = 1'b1;
        @(negedge clk);
        chk("flushresp_done", 32'(done), 32'd1);
        chk("flushresp_cause", 32'(cause), 32'(ERR_MISALIGN));
        step();
        flush = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
